// File: rtl/bin2bcd_seq_pkg.sv
// Shared helpers for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  // Bits per BCD digit.
  localparam int NIBBLE_W = 4;

  // Largest value representable in the given number of decimal digits (10^n - 1).
  function automatic longint unsigned pow10_minus1(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble when it is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Results are registered and held until the next conversion completes.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             bin,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]            blank,
  output logic                         ovf
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [63:0] LIMIT = 64'(pow10_minus1(DIGITS));
  // Reset shows a single '0': every digit but the least significant is blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   sr;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   corrected;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;
  logic [DIGITS-1:0]  blank_calc;
  logic               shifts_done;

  assign busy        = (state != IDLE);
  assign shifts_done = (cnt == CNT_W'(WIDTH));

  // Per-digit add-3 correction applied to the scratch register each SHIFT cycle.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d(scratch[NIBBLE_W*g +: NIBBLE_W]),
      .q(corrected[NIBBLE_W*g +: NIBBLE_W])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; the extra SHIFT cycle with the counter at WIDTH performs no shift.
  always_comb begin
    // NOTE: the default assignment first guarantees state_nxt is written on every
    // path, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)       state_nxt = SHIFT;
      SHIFT:   if (shifts_done) state_nxt = FINISH;
      FINISH:                   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Leading-zero flags: digit i (i >= 1) is blank when it and all higher digits are zero.
  always_comb begin
    logic zero_above;
    blank_calc = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (scratch[NIBBLE_W*i +: NIBBLE_W] == '0);
      blank_calc[i] = zero_above;
    end
  end

  // Datapath and output registers: load on accept, shift in SHIFT, publish in FINISH.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr       <= bin;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= (64'(bin) > LIMIT);
          end
        end
        SHIFT: begin
          if (!shifts_done) begin
            scratch <= {corrected[BCD_W-2:0], sr[WIDTH-1]};
            sr      <= sr << 1;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        FINISH: begin
          done  <= 1'b1;
          ovf   <= ovf_pend;
          bcd   <= ovf_pend ? '1 : scratch;
          blank <= ovf_pend ? '0 : blank_calc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, hand-written corner
// sequences, and random values checked against an arithmetic decimal model.
module tb_bin2bcd_seq;

  localparam int W = 20;
  localparam int D = 6;
  localparam int LAT = W + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [W-1:0]    bin;
  logic            busy;
  logic            done;
  logic [4*D-1:0]  bcd;
  logic [D-1:0]    blank;
  logic            ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   v;
    logic [4*D-1:0] e_bcd;
    logic [D-1:0]   e_blank;
    logic           e_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: digits by division, blanking by magnitude, ovf by range.
  function automatic void model(input int unsigned v, output logic [4*D-1:0] b,
                                output logic [D-1:0] bl, output logic o);
    int unsigned p;
    p  = 1;
    o  = (v > 999999);
    b  = '0;
    bl = '0;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'((v / p) % 10);
      bl[i]       = (i != 0) && (v < p);
      p           = p * 10;
    end
    if (o) begin
      b  = '1;
      bl = '0;
    end
  endfunction

  // One full conversion from idle: latency, busy length, hold, result, single pulse.
  task automatic run_conv(input logic [W-1:0] v, input logic [4*D-1:0] eb,
                          input logic [D-1:0] ebl, input logic eo, input string tag);
    int lat;
    int busy_cnt;
    logic held;
    logic [4*D-1:0] bcd0;
    logic [D-1:0] blank0;
    logic ovf0;
    lat = -1; busy_cnt = 0; held = 1'b1;
    bcd0 = bcd; blank0 = blank; ovf0 = ovf;
    bin = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin = W'($urandom);
    if (busy) busy_cnt++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      if (bcd !== bcd0 || blank !== blank0 || ovf !== ovf0) held = 1'b0;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    check({tag, "_hold"}, 64'(held), 64'(1));
    check({tag, "_bcd"}, 64'(bcd), 64'(eb));
    check({tag, "_blank"}, 64'(blank), 64'(ebl));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int ndone;
    logic [4*D-1:0] cap_bcd;
    logic [D-1:0] cap_blank;
    int dedge[$];
    logic [W-1:0] rv;
    logic [4*D-1:0] mb;
    logic [D-1:0] mbl;
    logic mo;

    vecs[0] = '{20'd0,       24'h000000, 6'b111110, 1'b0};
    vecs[1] = '{20'd123456,  24'h123456, 6'b000000, 1'b0};
    vecs[2] = '{20'd999999,  24'h999999, 6'b000000, 1'b0};
    vecs[3] = '{20'd1000000, 24'hFFFFFF, 6'b000000, 1'b1};
    vecs[4] = '{20'd42,      24'h000042, 6'b111100, 1'b0};
    vecs[5] = '{20'd555,     24'h000555, 6'b111000, 1'b0};
    vecs[6] = '{20'd7,       24'h000007, 6'b111110, 1'b0};
    vecs[7] = '{20'd1048575, 24'hFFFFFF, 6'b000000, 1'b1};
    vecs[8] = '{20'd100000,  24'h100000, 6'b000000, 1'b0};
    vecs[9] = '{20'd10,      24'h000010, 6'b111100, 1'b0};

    // Reset state.
    reset = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_bcd", 64'(bcd), 64'(0));
    check("rst_blank", 64'(blank), 64'(6'b111110));
    check("rst_ovf", 64'(ovf), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].v, vecs[i].e_bcd, vecs[i].e_blank, vecs[i].e_ovf, $sformatf("vec%0d", i));
    end

    // Start re-pulsed with a new bin mid-conversion: ignored, single done.
    bin = 20'd42; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = '0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; bin = 20'd7;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; cap_bcd = '0; cap_blank = '0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        cap_bcd = bcd;
        cap_blank = blank;
      end
    end
    check("busy_start_ndone", 64'(ndone), 64'(1));
    check("busy_start_bcd", 64'(cap_bcd), 64'(24'h000042));
    check("busy_start_blank", 64'(cap_blank), 64'(6'b111100));

    // Reset mid-conversion, with start asserted during the reset edge.
    bin = 20'd555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_bcd", 64'(bcd), 64'(0));
    check("abort_blank", 64'(blank), 64'(6'b111110));
    check("abort_ovf", 64'(ovf), 64'(0));
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'(0));
    check("abort_idle", 64'(busy), 64'(0));
    run_conv(20'd555, 24'h000555, 6'b111000, 1'b0, "after_abort");

    // Back-to-back: start held for 50 edges -> accepts at 0, 23, 46.
    bin = 20'd7; start = 1'b1;
    for (int e = 0; e < 100; e++) begin
      @(posedge clk); #1;
      if (e == 49) start = 1'b0;
      if (done) begin
        dedge.push_back(e);
        check($sformatf("b2b_bcd_%0d", e), 64'(bcd), 64'(24'h000007));
      end
    end
    check("b2b_count", 64'(dedge.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_edge%0d", i),
            64'((dedge.size() > i) ? dedge[i] : -1), 64'(22 + 23 * i));
    end

    // Randomized values against the decimal model, biased toward the overflow boundary.
    for (int n = 0; n < 24; n++) begin
      if (n % 3 == 0) rv = W'(999990 + $urandom_range(0, 20));
      else if (n % 3 == 1) rv = W'($urandom_range(0, 999));
      else rv = W'($urandom_range(0, (1 << W) - 1));
      model(32'(rv), mb, mbl, mo);
      run_conv(rv, mb, mbl, mo, $sformatf("rnd%0d_%0d", n, rv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 20, binary input width in bits.
REQ-002 Parameter DIGITS, default 6, number of BCD output digits; SHALL satisfy 4*DIGITS >= WIDTH.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request to convert bin; sampled on the rising edge of clk.
REQ-006 Port bin  input  WIDTH  unsigned binary value; sampled only when start is accepted.
REQ-007 Port busy  output  1  high while a conversion is in progress.
REQ-008 Port done  output  1  one-cycle pulse marking new result on bcd, blank and ovf.
REQ-009 Port bcd  output  4*DIGITS  result digits; digit i occupies bits [4i+3:4i], digit 0 least significant; each nibble feeds one hex_display instance.
REQ-010 Port blank  output  DIGITS  bit i high means digit i is a leading zero.
REQ-011 Port ovf  output  1  high when the last accepted bin exceeds 10^DIGITS-1.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and FINISH; busy = (state != IDLE).
REQ-013 In IDLE, start=1 SHALL be accepted: bin is latched into a WIDTH-bit shift register, a 4*DIGITS scratch register is cleared, the shift counter is cleared, ovf_next = (bin > 10^DIGITS-1), and the state becomes SHIFT.
REQ-014 In SHIFT, each cycle SHALL add 3 to every scratch nibble >= 5 and then shift {scratch, shift register} left by 1, with the counter incrementing.
REQ-015 After exactly WIDTH SHIFT cycles, the state SHALL become FINISH.
REQ-016 FINISH SHALL last one cycle; at its exit edge, bcd, blank and ovf are registered, done=1 for that one cycle, and the state returns to IDLE.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high from edge WIDTH+2 and remain high for one cycle; busy is high from edge 1 through edge WIDTH+2.
REQ-018 start while busy=1 SHALL be ignored (no queuing); start in the same cycle done=1 (state IDLE) SHALL be accepted.
REQ-019 bcd, blank and ovf SHALL hold their last values until the next done and SHALL NOT change during conversion.
REQ-020 Overflow: if ovf_next=1, bcd SHALL be all ones (every digit 0xF) and blank all zeros.
REQ-021 Blank: digit i (i >= 1) is blank iff it and every higher digit is zero; blank[0] SHALL always be 0, so value 0 shows a single 0.
REQ-022 bin changes while busy SHALL NOT affect the result.

Reset
REQ-023 While reset=1 at a clock edge: state=IDLE, busy=0, done=0, bcd=0, ovf=0, and blank = all ones except blank[0]=0.
REQ-024 Reset mid-conversion SHALL abort without asserting done; start in the same cycle as reset SHALL be ignored.
REQ-025 All outputs SHALL be driven directly from registers; no output depends combinationally on start or bin.

Structure
REQ-026 State encodings and the 10^DIGITS-1 limit SHALL be module-local constants; no shared package is required.
REQ-027 One sub-module, bcd_add3, SHALL implement the per-nibble "add 3 if >= 5" correction; it SHALL be instantiated DIGITS times by generate.
REQ-028 Total RTL SHALL be 120-400 lines.

Verification
REQ-029 Reset, then bin=0 and start -> done at edge 22, bcd=0x000000, blank=6'b111110, ovf=0.
REQ-030 bin=123456 (0x1E240) -> bcd=0x123456, blank=0, ovf=0; busy high for exactly 22 cycles.
REQ-031 bin=999999 -> bcd=0x999999, ovf=0; then bin=1000000 -> bcd=0xFFFFFF, ovf=1, blank=0.
REQ-032 bin=42, with start pulsed again and bin changed to 7 mid-conversion -> single done, bcd=0x000042, blank=6'b111100.
REQ-033 Reset asserted at cycle 10 of a conversion of 555 -> no done pulse, outputs at reset values; a fresh start with 555 -> bcd=0x000555.
REQ-034 Back-to-back: start held high for 50 cycles with bin=7 -> done every 23 cycles, bcd=0x000007 each time.
